// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: default field widths and the sequencer state encoding.
// The ROM word is {note, duration}; a zero duration marks the end of a song.
package song_reader_pkg;

  localparam int SONG_BITS_DEF      = 2;
  localparam int NOTE_ADDR_BITS_DEF = 5;
  localparam int NOTE_BITS_DEF      = 6;
  localparam int DUR_BITS_DEF       = 6;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_ROM  = 3'd2,
    S_NEXT_NOTE = 3'd3,
    S_WAIT_NOTE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/song_reader_note_index_counter.sv
// Note index up-counter with synchronous clear (priority) and enable.
// terminal_o flags the last addressable note so the sequencer can end the song instead of wrapping.
module note_index_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o,
  output logic             terminal_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clear_i)       count_d = '0;
    else if (enable_i) count_d = count_q + 1'b1;
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o    = count_q;
  assign terminal_o = &count_q;

endmodule

// File: rtl/song_reader.sv
// Walks one song's note list in a synchronous ROM and hands notes to note_player one at a time
// (new_note / note_done handshake), pulsing song_done once at the end of the song.
module song_reader
  import song_reader_pkg::*;
#(
  parameter int SONG_BITS      = SONG_BITS_DEF,
  parameter int NOTE_ADDR_BITS = NOTE_ADDR_BITS_DEF,
  parameter int NOTE_BITS      = NOTE_BITS_DEF,
  parameter int DUR_BITS       = DUR_BITS_DEF
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                play,
  input  logic                                reset_play,
  input  logic [SONG_BITS-1:0]                song,
  input  logic                                note_done,
  output logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr,
  input  logic [NOTE_BITS+DUR_BITS-1:0]       rom_data,
  output logic [NOTE_BITS-1:0]                note,
  output logic [DUR_BITS-1:0]                 duration,
  output logic                                new_note,
  output logic                                song_done
);

  state_t                    state_q;
  logic [NOTE_BITS-1:0]      note_q;
  logic [DUR_BITS-1:0]       duration_q;
  logic                      new_note_q;
  logic                      song_done_q;
  logic [NOTE_ADDR_BITS-1:0] note_idx;
  logic                      idx_last;
  logic                      idx_advance;
  logic [NOTE_BITS-1:0]      rom_note;
  logic [DUR_BITS-1:0]       rom_dur;

  assign rom_note = rom_data[NOTE_BITS+DUR_BITS-1:DUR_BITS];
  assign rom_dur  = rom_data[DUR_BITS-1:0];

  // The index moves only when a note finishes and it is not the last slot; reset_play clears it.
  assign idx_advance = (state_q == S_WAIT_NOTE) && note_done && !idx_last;

  note_index_counter #(
    .WIDTH (NOTE_ADDR_BITS)
  ) u_note_index_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (reset_play),
    .enable_i   (idx_advance),
    .count_o    (note_idx),
    .terminal_o (idx_last)
  );

  // Song changes take effect on the address immediately; the sequence position is kept.
  assign rom_addr = {song, note_idx};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else if (reset_play) begin
      state_q     <= S_IDLE;
      note_q      <= '0;
      duration_q  <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      case (state_q)
        S_IDLE:      if (play) state_q <= S_FETCH;
        S_FETCH:     state_q <= S_WAIT_ROM;
        S_WAIT_ROM: begin
          // While paused the ROM keeps re-reading the same address, so waiting here is safe.
          if (rom_dur == '0) begin
            state_q     <= S_DONE;
            song_done_q <= 1'b1;
          end else if (play) begin
            state_q    <= S_NEXT_NOTE;
            note_q     <= rom_note;
            duration_q <= rom_dur;
            new_note_q <= 1'b1;
          end
        end
        S_NEXT_NOTE: state_q <= S_WAIT_NOTE;
        S_WAIT_NOTE: begin
          if (note_done) begin
            if (idx_last) begin
              state_q     <= S_DONE;
              song_done_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE:      state_q <= S_DONE;
        default:     state_q <= S_IDLE;
      endcase
    end
  end

  assign note      = note_q;
  assign duration  = duration_q;
  assign new_note  = new_note_q;
  assign song_done = song_done_q;

endmodule

// File: tb/tb_song_reader.sv
// Self-checking bench for song_reader: a behavioural ROM plus a reference walk of each song's
// note list derived from the ROM contents, with latency and end-of-song expectations.
module tb_song_reader;
  import song_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        play;
  logic        reset_play;
  logic [1:0]  song;
  logic        note_done;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic        new_note;
  logic        song_done;

  logic [11:0] rom_mem [128];

  int total = 0;
  int bad   = 0;

  song_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .play       (play),
    .reset_play (reset_play),
    .song       (song),
    .note_done  (note_done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    play       = 1'b0;
    note_done  = 1'b0;
    reset_play = 1'b1;
    step();
    reset_play = 1'b0;
  endtask

  // Expected notes of song s: entries from index 0 up to the first zero duration, at most 32.
  task automatic build_expected(input logic [1:0] s, output logic [11:0] exp_q[$]);
    logic [11:0] e;
    exp_q = {};
    for (int i = 0; i < 32; i++) begin
      e = rom_mem[{s, 5'(i)}];
      if (e[5:0] == 6'd0) break;
      exp_q.push_back(e);
    end
  endtask

  // Plays song s from IDLE to DONE; gap=0 picks a random note length. spam drives note_done in DONE.
  task automatic run_song(input logic [1:0] s, input int gap, input bit spam, input string tag);
    logic [11:0] exp_q[$];
    int c, d, extra_nn, extra_sd, exp_lat;
    build_expected(s, exp_q);
    song = s;
    play = 1'b1;
    step();
    c = 1;
    for (int k = 0; k < exp_q.size(); k++) begin
      while (new_note !== 1'b1 && c < 40) begin
        step();
        c++;
      end
      total++;
      if (new_note !== 1'b1 || c != 3) begin
        bad++;
        $display("FAIL %s latency note %0d: got %0d cycles (new_note=%b), want 3", tag, k, c, new_note);
      end
      total++;
      if ({note, duration} !== exp_q[k]) begin
        bad++;
        $display("FAIL %s data note %0d: got %0d/%0d, want %0d/%0d", tag, k, note, duration,
                 exp_q[k][11:6], exp_q[k][5:0]);
      end
      total++;
      if (rom_addr !== {s, 5'(k)}) begin
        bad++;
        $display("FAIL %s rom_addr note %0d: got %h, want %h", tag, k, rom_addr, {s, 5'(k)});
      end
      d = (gap > 0) ? gap : int'($urandom_range(1, 6));
      extra_nn = 0;
      for (int j = 0; j < d; j++) begin
        step();
        if (new_note === 1'b1) extra_nn++;
      end
      total++;
      if (extra_nn != 0 || {note, duration} !== exp_q[k]) begin
        bad++;
        $display("FAIL %s hold note %0d: extra new_note=%0d, got %0d/%0d", tag, k, extra_nn, note, duration);
      end
      note_done = 1'b1;
      step();
      note_done = 1'b0;
      c = 1;
    end
    while (song_done !== 1'b1 && c < 10) begin
      step();
      c++;
    end
    exp_lat = (exp_q.size() == 32) ? 1 : 3;
    total++;
    if (song_done !== 1'b1 || c != exp_lat) begin
      bad++;
      $display("FAIL %s song_done: got %0d cycles (song_done=%b), want %0d", tag, c, song_done, exp_lat);
    end
    extra_nn = 0;
    extra_sd = 0;
    for (int j = 0; j < 50; j++) begin
      if (spam) note_done = 1'($urandom_range(0, 1));
      step();
      if (new_note === 1'b1)  extra_nn++;
      if (song_done === 1'b1) extra_sd++;
    end
    note_done = 1'b0;
    total++;
    if (extra_nn != 0 || extra_sd != 0 || dut.state_q !== S_DONE) begin
      bad++;
      $display("FAIL %s stay_done: new_note=%0d song_done=%0d state=%0d, want 0 0 %0d", tag,
               extra_nn, extra_sd, dut.state_q, S_DONE);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    total++;
    if ({note, duration, new_note, song_done} !== 14'd0 || dut.state_q !== S_IDLE) begin
      bad++;
      $display("FAIL reset_outputs: got %0d/%0d nn=%b sd=%b state=%0d, want zeros and IDLE",
               note, duration, new_note, song_done, dut.state_q);
    end
    #2 reset_n = 1'b1;
    repeat (3) step();
    total++;
    if (new_note !== 1'b0 || rom_addr !== 7'h00 || dut.state_q !== S_IDLE) begin
      bad++;
      $display("FAIL reset_idle: nn=%b addr=%h state=%0d, want 0 00 IDLE", new_note, rom_addr, dut.state_q);
    end
  endtask

  task automatic test_basic_song();
    restart();
    run_song(2'd1, 4, 1'b0, "basic");
  endtask

  task automatic test_pause_in_wait_rom();
    int nn;
    logic changed;
    restart();
    song = 2'd2;
    play = 1'b1;
    step();
    play = 1'b0;
    step();
    nn = 0;
    changed = 1'b0;
    for (int j = 0; j < 20; j++) begin
      step();
      if (new_note === 1'b1) nn++;
      if (rom_addr !== 7'h40) changed = 1'b1;
    end
    total++;
    if (nn != 0 || changed) begin
      bad++;
      $display("FAIL pause: new_note=%0d addr_changed=%b, want 0 0", nn, changed);
    end
    play = 1'b1;
    step();
    total++;
    if (new_note !== 1'b1 || {note, duration} !== rom_mem[7'h40]) begin
      bad++;
      $display("FAIL resume: nn=%b data=%h, want 1 %h", new_note, {note, duration}, rom_mem[7'h40]);
    end
  endtask

  task automatic test_reset_play_collision();
    int c, nn;
    restart();
    song = 2'd2;
    play = 1'b1;
    c = 0;
    while (new_note !== 1'b1 && c < 20) begin step(); c++; end
    step();
    note_done = 1'b1;
    step();
    note_done = 1'b0;
    c = 1;
    while (new_note !== 1'b1 && c < 20) begin step(); c++; end
    total++;
    if ({note, duration} !== rom_mem[7'h41]) begin
      bad++;
      $display("FAIL collide_setup: got %h, want %h", {note, duration}, rom_mem[7'h41]);
    end
    step();
    reset_play = 1'b1;
    note_done  = 1'b1;
    play       = 1'b0;
    step();
    reset_play = 1'b0;
    note_done  = 1'b0;
    total++;
    if ({note, duration} !== 12'd0 || rom_addr !== 7'h40 || new_note !== 1'b0) begin
      bad++;
      $display("FAIL collide_clear: data=%h addr=%h nn=%b, want 000 40 0", {note, duration}, rom_addr, new_note);
    end
    nn = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (new_note === 1'b1) nn++;
    end
    total++;
    if (nn != 0) begin
      bad++;
      $display("FAIL collide_idle: new_note=%0d, want 0", nn);
    end
    play = 1'b1;
    step();
    c = 1;
    while (new_note !== 1'b1 && c < 20) begin step(); c++; end
    total++;
    if (c != 3 || {note, duration} !== rom_mem[7'h40]) begin
      bad++;
      $display("FAIL collide_restart: %0d cycles data=%h, want 3 %h", c, {note, duration}, rom_mem[7'h40]);
    end
  endtask

  task automatic test_full_song();
    restart();
    run_song(2'd3, 0, 1'b0, "full32");
  endtask

  task automatic test_random_song();
    restart();
    run_song(2'd0, 0, 1'b0, "random");
  endtask

  task automatic test_async_reset();
    int c, nn;
    restart();
    song = 2'd3;
    play = 1'b1;
    c = 0;
    while (new_note !== 1'b1 && c < 20) begin step(); c++; end
    step();
    song = 2'd0;
    #1;
    total++;
    if (rom_addr !== 7'h00) begin
      bad++;
      $display("FAIL song_change: addr=%h, want 00", rom_addr);
    end
    song = 2'd3;
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({note, duration, new_note, song_done} !== 14'd0 || rom_addr !== 7'h60 || dut.state_q !== S_IDLE) begin
      bad++;
      $display("FAIL async_reset: data=%h nn=%b sd=%b addr=%h state=%0d, want zeros 60 IDLE",
               {note, duration}, new_note, song_done, rom_addr, dut.state_q);
    end
    play = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    nn = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (new_note === 1'b1) nn++;
    end
    total++;
    if (nn != 0 || dut.state_q !== S_IDLE) begin
      bad++;
      $display("FAIL after_reset: new_note=%0d state=%0d, want 0 IDLE", nn, dut.state_q);
    end
  endtask

  task automatic test_done_ignores_inputs();
    restart();
    run_song(2'd1, 0, 1'b1, "done_spam");
  endtask

  initial begin
    int n0;
    play       = 1'b0;
    reset_play = 1'b0;
    song       = 2'd0;
    note_done  = 1'b0;
    for (int i = 0; i < 128; i++) rom_mem[i] = 12'd0;
    n0 = int'($urandom_range(1, 10));
    for (int i = 0; i < n0; i++)
      rom_mem[7'(i)] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
    rom_mem[7'h20] = {6'd5, 6'd10};
    rom_mem[7'h21] = {6'd7, 6'd3};
    for (int i = 0; i < 4; i++)
      rom_mem[7'h40 + 7'(i)] = {6'($urandom_range(1, 63)), 6'($urandom_range(1, 63))};
    for (int i = 0; i < 32; i++)
      rom_mem[7'h60 + 7'(i)] = {6'($urandom_range(1, 63)), 6'($urandom_range(1, 63))};

    test_reset();
    test_basic_song();
    test_pause_in_wait_rom();
    test_reset_play_collision();
    test_full_song();
    test_random_song();
    test_async_reset();
    test_done_ignores_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
